fixed_to_float: RTL and testbench

FIXED_TO_FLOAT -- requirements
Module: fixed_to_float

---
 rtl/fixed_to_float.sv | 131 +++++++++++++
 tb/tb_fixed_to_float.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float.sv
// Converts a signed Q16.16 fixed-point operand to IEEE-754 single precision,
// one operand at a time, over a stb/ack handshake on each side.
module fixed_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic        output_z_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb
);

  typedef enum logic [2:0] {
    GET_A     = 3'd0,
    UNPACK    = 3'd1,
    NORMALISE = 3'd2,
    ROUND     = 3'd3,
    PACK      = 3'd4,
    PUT_Z     = 3'd5
  } state_t;

  state_t state_reg, state_next;

  logic        ack_reg, ack_next;
  logic        stb_reg, stb_next;
  logic [31:0] a_reg;
  logic        s_reg;
  logic [31:0] m_reg;
  logic signed [5:0] e_reg;
  logic [23:0] mant_reg;
  logic        zero_reg;
  logic [31:0] z_reg;

  logic        a_fire;
  logic        z_fire;
  logic        round_up;
  logic [24:0] mant_sum;
  logic [7:0]  biased_exp;

  assign a_fire = (state_reg == GET_A) && ack_reg && input_a_stb;
  assign z_fire = (state_reg == PUT_Z) && stb_reg && output_z_ack;

  // Round to nearest, ties to even, on the bits below the 24-bit mantissa.
  assign round_up   = m_reg[7] && ((|m_reg[6:0]) || m_reg[8]);
  assign mant_sum   = {1'b0, m_reg[31:8]} + {24'd0, round_up};
  assign biased_exp = {{2{e_reg[5]}}, e_reg} + 8'd127;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= GET_A;
      ack_reg   <= 1'b0;
      stb_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
      stb_reg   <= stb_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      GET_A:     if (a_fire) state_next = UNPACK;
      // Zero skips normalise/round; PACK emits the zero word.
      UNPACK:    state_next = (a_reg == 32'd0) ? PACK : NORMALISE;
      NORMALISE: if (m_reg[31]) state_next = ROUND;
      ROUND:     state_next = PACK;
      PACK:      state_next = PUT_Z;
      PUT_Z:     if (z_fire) state_next = GET_A;
      default:   state_next = GET_A;
    endcase
  end

  // Handshake outputs are registered so they follow the state exactly.
  always_comb begin
    ack_next = (state_next == GET_A);
    stb_next = (state_next == PUT_Z);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= 32'd0;
      s_reg    <= 1'b0;
      m_reg    <= 32'd0;
      e_reg    <= 6'sd0;
      mant_reg <= 24'd0;
      zero_reg <= 1'b0;
      z_reg    <= 32'd0;
    end else begin
      case (state_reg)
        GET_A: begin
          if (a_fire) a_reg <= input_a;
        end
        UNPACK: begin
          s_reg    <= a_reg[31];
          // Negating 0x80000000 wraps back to 0x80000000, the correct magnitude.
          m_reg    <= a_reg[31] ? (~a_reg + 32'd1) : a_reg;
          e_reg    <= 6'sd15;
          zero_reg <= (a_reg == 32'd0);
        end
        NORMALISE: begin
          if (!m_reg[31]) begin
            m_reg <= m_reg << 1;
            e_reg <= e_reg - 6'sd1;
          end
        end
        ROUND: begin
          if (mant_sum[24]) begin
            mant_reg <= 24'h800000;
            e_reg    <= e_reg + 6'sd1;
          end else begin
            mant_reg <= mant_sum[23:0];
          end
        end
        PACK: begin
          z_reg <= zero_reg ? 32'd0 : {s_reg, biased_exp, mant_reg[22:0]};
        end
        default: ;
      endcase
    end
  end

  assign input_a_ack  = ack_reg;
  assign output_z_stb = stb_reg;
  assign output_z     = z_reg;

endmodule

// File: tb/tb_fixed_to_float.sv
// Self-checking bench for fixed_to_float: directed corner values, backpressure,
// reset behaviour and randomized operands against an arithmetic reference.
module tb_fixed_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic        output_z_ack;
  logic [31:0] output_z;
  logic        output_z_stb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fixed_to_float dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z_ack (output_z_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact value |a| * 2^-16, rounded to 24 significant bits (RNE).
  function automatic logic [31:0] ref_f(input logic [31:0] a);
    logic [63:0] mag;
    logic [63:0] q;
    logic [63:0] rem;
    logic [63:0] half;
    logic        sgn;
    logic [7:0]  be;
    int          p;
    int          ex;
    int          sh;
    sgn = a[31];
    mag = sgn ? (64'd1 << 32) - {32'd0, a} : {32'd0, a};
    if (mag == 64'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 33; i++) if (mag[i]) p = i;
    ex = p - 16;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    end else begin
      q = mag << (23 - p);
    end
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    be = 8'(ex + 127);
    return {sgn, be, q[22:0]};
  endfunction

  // One conversion. gap == 0: consumer holds ack high throughout.
  // gap > 0: ack held low for gap cycles in PUT_Z, stability checked each cycle.
  task automatic conv(input logic [31:0] a, input int exp_lat, input int gap);
    int lat;
    int w;
    logic [31:0] exp_z;
    logic [31:0] held;
    exp_z = ref_f(a);
    output_z_ack = (gap == 0);
    w = 0;
    while (!input_a_ack && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check_eq("ack_wait", {31'd0, input_a_ack}, 32'd1);
    input_a     = a;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    input_a     = $urandom;
    lat = 0;
    while (!output_z_stb && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (exp_lat >= 0) check_eq("latency", lat, exp_lat);
    check_eq($sformatf("z(%h)", a), output_z, exp_z);
    check_eq("ack_in_put", {31'd0, input_a_ack}, 32'd0);
    held = output_z;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      if (output_z !== held || output_z_stb !== 1'b1 || input_a_ack !== 1'b0)
        check_eq("hold", {output_z_stb, input_a_ack, 30'd0} ^ output_z, {2'b10, 30'd0} ^ held);
      else n_cmp++;
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = (gap == 0);
    check_eq("stb_after", {31'd0, output_z_stb}, 32'd0);
    check_eq("ack_after", {31'd0, input_a_ack}, 32'd1);
    check_eq("z_kept", output_z, exp_z);
    $display("conv a=%h z=%h exp=%h lat=%0d gap=%0d", a, output_z, exp_z, lat, gap);
  endtask

  task automatic expect_silence(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (output_z_stb) seen++;
    end
    check_eq(tag, seen, 0);
  endtask

  initial begin
    logic [31:0] ra;
    rst          = 1'b1;
    input_a      = 32'd0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", {31'd0, input_a_ack}, 32'd0);
    check_eq("rst_stb", {31'd0, output_z_stb}, 32'd0);
    check_eq("rst_z", output_z, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("ack_after_rst", {31'd0, input_a_ack}, 32'd1);

    // Directed values
    conv(32'h00010000, 19, 0);
    conv(32'hFFFF0000, 19, 0);
    conv(32'h00018000, 19, 0);
    conv(32'h80000000, 4, 0);
    conv(32'h00000001, 35, 0);
    conv(32'h00000000, 2, 0);
    conv(32'h01000001, -1, 0);
    conv(32'h01000003, -1, 0);
    conv(32'h7FFFFFFF, 5, 0);

    // Backpressure
    conv(32'h00030000, -1, 10);

    // Reset mid-normalise
    input_a     = 32'h00000001;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_z", output_z, 32'd0);
    check_eq("midrst_stb", {31'd0, output_z_stb}, 32'd0);
    rst = 1'b0;
    expect_silence("midrst_no_out", 40);
    conv(32'h00010000, 19, 0);

    // Reset wins over a simultaneous strobe
    rst         = 1'b1;
    input_a     = 32'h00010000;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    input_a_stb = 1'b0;
    expect_silence("rst_stb_no_out", 40);

    // Random operands with random gaps
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = $urandom >> $urandom_range(0, 31);
        2: ra = -($urandom >> $urandom_range(0, 31));
        default: ra = {$urandom_range(0, 1) ? 8'hFF : 8'h00, 24'($urandom)};
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      conv(ra, -1, $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
